// File: rtl/pulse_generator_if.sv
// Signal bundle between the HPS pulse PIO exports and the fabric pulse generator.
// The master side drives the timing words and start level; the slave side returns status.
interface pulse_generator_if #(
    parameter int unsigned CNT_W = 32
) ();
    logic             pulse_start_i;
    logic [CNT_W-1:0] pulse_delay_i;
    logic [CNT_W-1:0] pulse_width_i;
    logic [CNT_W-1:0] pulse_repetition_i;
    logic             pulse_o;
    logic             busy_o;
    logic [CNT_W-1:0] pulse_count_o;

    modport master (
        output pulse_start_i,
        output pulse_delay_i,
        output pulse_width_i,
        output pulse_repetition_i,
        input  pulse_o,
        input  busy_o,
        input  pulse_count_o
    );

    modport slave (
        input  pulse_start_i,
        input  pulse_delay_i,
        input  pulse_width_i,
        input  pulse_repetition_i,
        output pulse_o,
        output busy_o,
        output pulse_count_o
    );
endinterface

// File: rtl/pulse_generator.sv
// Turns HPS-written delay/width/repetition words into a cycle-accurate pulse train.
// Define PULSE_GEN_START_SYNC_EN to pass the start level through a 2-flop synchronizer.
module pulse_generator #(
    parameter int unsigned CNT_W = 32
) (
    input logic              clk_clk,
    input logic              reset_reset,
    pulse_generator_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StDelay,
        StHigh,
        StLow,
        StHold
    } state_e;

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] low_len_q, low_len_d;
    logic             single_q, single_d;
    logic             pulse_q, pulse_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             start_q;
    logic             start;
    logic             start_rise;
    logic [CNT_W-1:0] width_plus1;
    logic [CNT_W-1:0] period_eff;
    logic [CNT_W-1:0] count_inc;

`ifdef PULSE_GEN_START_SYNC_EN
    logic [1:0] sync_q;

    // Reset high so a start level held through reset cannot look like a fresh edge.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.pulse_start_i};
        end
    end

    assign start = sync_q[1];
`else
    assign start = bus.pulse_start_i;
`endif

    assign start_rise  = start & ~start_q;
    assign width_plus1 = (bus.pulse_width_i == '1) ? bus.pulse_width_i : bus.pulse_width_i + One;
    // Single shot never uses the LOW length, so give it a harmless non-underflowing period.
    assign period_eff  = (bus.pulse_repetition_i == '0)         ? width_plus1 :
                         (bus.pulse_repetition_i > width_plus1) ? bus.pulse_repetition_i :
                                                                  width_plus1;
    assign count_inc   = (count_q == '1) ? count_q : count_q + One;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        low_len_d = low_len_q;
        single_d  = single_q;
        pulse_d   = pulse_q;
        count_d   = count_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise && (bus.pulse_width_i != '0)) begin
                    width_d   = bus.pulse_width_i;
                    low_len_d = period_eff - bus.pulse_width_i;
                    single_d  = (bus.pulse_repetition_i == '0);
                    if (bus.pulse_delay_i == '0) begin
                        state_d = StHigh;
                        cnt_d   = bus.pulse_width_i;
                        pulse_d = 1'b1;
                        count_d = One;
                    end else begin
                        state_d = StDelay;
                        cnt_d   = bus.pulse_delay_i;
                        count_d = '0;
                    end
                end
            end
            StDelay: begin
                if (!start) begin
                    state_d = StIdle;
                end else if (cnt_q == One) begin
                    state_d = StHigh;
                    cnt_d   = width_q;
                    pulse_d = 1'b1;
                    count_d = count_inc;
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StHigh: begin
                if (cnt_q == One) begin
                    pulse_d = 1'b0;
                    if (single_q) begin
                        state_d = StHold;
                    end else if (!start) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StLow;
                        cnt_d   = low_len_q;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StLow: begin
                // A zero LOW length only arises when W+1 saturated; treat it as one cycle.
                if (cnt_q <= One) begin
                    if (start) begin
                        state_d = StHigh;
                        cnt_d   = width_q;
                        pulse_d = 1'b1;
                        count_d = count_inc;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - One;
                end
            end
            StHold: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                pulse_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            width_q   <= '0;
            low_len_q <= '0;
            single_q  <= 1'b0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            start_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            low_len_q <= low_len_d;
            single_q  <= single_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            start_q   <= start;
        end
    end

    assign bus.pulse_o       = pulse_q;
    assign bus.busy_o        = (state_q != StIdle);
    assign bus.pulse_count_o = count_q;

endmodule

// File: tb/tb_pulse_generator.sv
// Self-checking bench for pulse_generator: directed cases plus randomized runs against
// a closed-form model of pulse rise times, widths and idle time.
module tb_pulse_generator;

`ifdef PULSE_GEN_START_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pulse_generator_if #(.CNT_W(32)) bus ();

    pulse_generator #(.CNT_W(32)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bus)
    );

    task automatic chk(input string tag, input int t, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Start rises before edge S, detector sees it at E = S + SYNC; start is seen low from E+hold.
    // Pulse k rises at d + k*p and exists while start was still high at that edge.
    task automatic run_case(input int d, input int w, input int rep, input int hold);
        int          p, n, idle, k, x, t, cnt_exp, r;
        logic        pe;
        p = (rep == 0) ? 0 : ((rep > w + 1) ? rep : w + 1);
        if (d > 0 && hold <= d) begin
            n    = 0;
            idle = hold;
        end else if (p == 0) begin
            n    = 1;
            idle = (hold > d + w + 1) ? hold : d + w + 1;
        end else begin
            k = 0;
            while (d + (k + 1) * p < hold) k++;
            n    = k + 1;
            x    = d + k * p + w;
            idle = (hold <= x) ? x : d + (k + 1) * p;
        end
        bus.pulse_delay_i      = 32'(d);
        bus.pulse_width_i      = 32'(w);
        bus.pulse_repetition_i = 32'(rep);
        bus.pulse_start_i      = 1'b1;
        for (int e = 0; e <= SYNC + idle + 2; e++) begin
            tick();
            t = e - SYNC;
            if (e == hold - 1) bus.pulse_start_i = 1'b0;
            if (t < 0) begin
                chk("busy_presync", t, 32'(bus.busy_o), 32'd0);
            end else begin
                pe      = 1'b0;
                cnt_exp = 0;
                for (int j = 0; j < n; j++) begin
                    r = d + j * p;
                    if (r <= t) cnt_exp++;
                    if (r <= t && t < r + w) pe = 1'b1;
                end
                chk("pulse", t, 32'(bus.pulse_o), 32'(pe));
                chk("busy", t, 32'(bus.busy_o), 32'(t < idle));
                chk("count", t, bus.pulse_count_o, 32'(cnt_exp));
                // Words written while busy must be ignored.
                bus.pulse_delay_i      = $urandom;
                bus.pulse_width_i      = $urandom;
                bus.pulse_repetition_i = $urandom;
            end
        end
        tick();
    endtask

    initial begin
        rst                    = 1'b1;
        bus.pulse_start_i      = 1'b1;
        bus.pulse_delay_i      = '0;
        bus.pulse_width_i      = 32'd4;
        bus.pulse_repetition_i = '0;
        repeat (3) tick();
        chk("rst_pulse", 0, 32'(bus.pulse_o), 32'd0);
        chk("rst_busy", 0, 32'(bus.busy_o), 32'd0);
        chk("rst_count", 0, bus.pulse_count_o, 32'd0);

        // Start already high out of reset must not trigger.
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("start_high_after_rst", i, 32'(bus.busy_o), 32'd0);
        end
        bus.pulse_start_i = 1'b0;
        repeat (4) tick();

        run_case(5, 3, 0, 10);    // single shot
        run_case(0, 2, 10, 35);   // train
        run_case(2, 8, 4, 30);    // period clamped to 9
        run_case(100, 5, 7, 41);  // abort in DELAY
        run_case(0, 3, 5, 2);     // start falls during first HIGH
        run_case(1, 2, 6, 8);     // start fall meets HIGH->LOW edge

        // Zero width start is ignored.
        bus.pulse_delay_i      = '0;
        bus.pulse_width_i      = '0;
        bus.pulse_repetition_i = 32'd3;
        bus.pulse_start_i      = 1'b1;
        for (int i = 0; i < SYNC + 5; i++) begin
            tick();
            chk("w0_busy", i, 32'(bus.busy_o), 32'd0);
            chk("w0_pulse", i, 32'(bus.pulse_o), 32'd0);
        end
        bus.pulse_start_i = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 20; i++) begin
            run_case(int'($urandom_range(8, 0)), int'($urandom_range(6, 1)),
                     int'($urandom_range(12, 0)), int'($urandom_range(40, 1)));
        end

        // Reset during HIGH clears everything on the next edge.
        bus.pulse_delay_i      = '0;
        bus.pulse_width_i      = 32'd20;
        bus.pulse_repetition_i = '0;
        bus.pulse_start_i      = 1'b1;
        repeat (SYNC + 4) tick();
        chk("pre_rst_pulse", 3, 32'(bus.pulse_o), 32'd1);
        chk("pre_rst_count", 3, bus.pulse_count_o, 32'd1);
        rst = 1'b1;
        tick();
        chk("midrst_pulse", 0, 32'(bus.pulse_o), 32'd0);
        chk("midrst_busy", 0, 32'(bus.busy_o), 32'd0);
        chk("midrst_count", 0, bus.pulse_count_o, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_busy", i, 32'(bus.busy_o), 32'd0);
        end
        bus.pulse_start_i = 1'b0;
        repeat (3) tick();
        run_case(3, 2, 0, 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
